demux_1to4: RTL

Registered 1-to-4 demultiplexer with a valid/ready handshake on each side: a single input stream is routed to one of four output channels picked by the 2-bit select `{s2,s1}`. It sits downstream of the 4-to-1 selection logic and uses the same select encoding and the same one-hot channel codes: a=1000, b=0100, c=0010, d=0001. A one-entry holding register gives one-cycle latency and full throughput, and optional per-channel transfer counters support bring-up.

---
 rtl/demux_1to4.sv | 74 +++++++
 1 files changed

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demux, one-entry hold, 1-cycle latency; in_ready = empty or draining, entry held while stalled.
// Per-channel transfer counters are built only when DEMUX_1TO4_CNT_EN is defined.
module demux_1to4 #(
  parameter int WIDTH = 1,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s1,
  input  logic             s2,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [1:0]       cnt_sel,
  output logic [CNTW-1:0]  cnt_out
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [3:0]       code;
    logic [WIDTH-1:0] dat;
  } entry_t;

  state_t state;
  entry_t ent;
  logic   acc;
  logic   drn;

  assign drn       = |(ent.code & out_ready);
  assign in_ready  = ~rst & ((state == EMPTY) | drn);
  assign acc       = in_valid & in_ready;
  assign out_valid = ent.code;
  assign out_data  = ent.dat;

  // acc already implies EMPTY or a drain, so a load needs no further qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ent   <= '0;
    end else if (acc) begin
      state    <= FULL;
      ent.code <= 4'b1000 >> {s2, s1};
      ent.dat  <= in_data;
    end else if (drn) begin
      state    <= EMPTY;
      ent.code <= 4'b0000;
    end
  end

`ifdef DEMUX_1TO4_CNT_EN
  logic [CNTW-1:0] cnt [4];

  // Counter index 0 is channel a, which is out_valid bit 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ent.code[3-i] & out_ready[3-i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign cnt_out = cnt[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out = '0;
`endif

endmodule
